ysyx_24120013_ifetch: RTL
=========================

Name: ysyx_24120013_ifetch

Overview:
Instruction fetch stage sitting directly upstream of the decode unit (IDU).
- Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request channel; accepts a separate valid-only response channel.
- Presents each fetched instruction and its PC to the IDU over a valid/ready handshake.
- Accepts a redirect (jump/branch target) from the execute side and flushes any in-flight fetch.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address.
DATA_WIDTH, 32, instruction word width.
RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low (0 = in reset).
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_req_addr  output  ADDR_WIDTH  fetch address, bits [1:0] always 0.
imem_rsp_valid  input  1  response data valid (one-cycle pulse).
imem_rsp_data  input  DATA_WIDTH  instruction word.
imem_rsp_err  input  1  access fault, qualified by imem_rsp_valid.
inst_valid  output  1  instruction available to IDU.
inst_ready  input  1  IDU consumes instruction.
inst  output  DATA_WIDTH  instruction word.
inst_pc  output  ADDR_WIDTH  PC of inst.
redirect_en  input  1  load redirect_pc as next fetch PC.
redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] forced to 0.
fetch_err  output  1  sticky access-fault flag.

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, drop flag=0.
- States: IDLE, REQ, WAIT, OUT, HALT.
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req_valid=1, addr=pc. On imem_req_valid & imem_req_ready -> WAIT. Addr stable while not accepted, except on redirect.
- WAIT: imem_req_valid=0. On imem_rsp_valid:
  - drop=1: discard data, clear drop -> REQ.
  - err=1: fetch_err=1 -> HALT.
  - else: latch inst=data, inst_pc=pc, inst_valid=1 -> OUT.
- OUT: inst/inst_pc held stable while inst_valid & !inst_ready. On inst_ready: inst_valid=0, pc=pc+4 -> REQ.
- Latency: minimum 3 cycles per instruction with zero-wait memory (REQ accept, response, IDU handshake). No back-to-back overlap; one request outstanding max.
- PC arithmetic: modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC+4 wraps to 0.
- Redirect (priority over every other event in the same cycle):
  - REQ, request not accepted: pc=redirect_pc, stay REQ, new addr next cycle.
  - REQ, request accepted in same cycle: pc=redirect_pc, drop=1 -> WAIT.
  - WAIT: pc=redirect_pc, drop=1; if imem_rsp_valid in same cycle, discard it -> REQ.
  - OUT: inst_valid=0, pc=redirect_pc -> REQ. If inst_ready was also 1, that transfer counts as completed (IDU sampled it); no pc+4.
  - HALT: pc=redirect_pc, fetch_err cleared -> REQ.
  - IDLE: pc=redirect_pc, -> REQ.
- HALT: no requests, inst_valid=0, fetch_err=1 until redirect or reset.
- imem_rsp_valid outside WAIT: ignored.
- Reset mid-operation: all state cleared immediately; any response that arrives after reset release is ignored until a new request is issued.

Optional Feature:
IFETCH_PERF_EN
- Defined: adds outputs perf_fetch_cnt [31:0] and perf_stall_cnt [31:0].
  - perf_fetch_cnt increments on each inst_valid & inst_ready.
  - perf_stall_cnt increments on every cycle in REQ or WAIT.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset release, zero-wait memory returning 32'h0000_0013 -> first request addr 32'h8000_0000; inst_valid with inst_pc=32'h8000_0000; next request 32'h8000_0004.
2. inst_ready held 0 for 5 cycles in OUT -> inst and inst_pc stable; no new imem_req_valid until inst_ready=1.
3. redirect_en with redirect_pc=32'h8000_0103 during WAIT; response 32'hDEAD_BEEF follows -> response discarded, next request addr 32'h8000_0100, no inst_valid for DEADBEEF.
4. Response with imem_rsp_err=1 -> fetch_err=1, no further requests for 10 cycles; then redirect to 32'h8000_0200 -> fetch_err=0, request at 32'h8000_0200.
5. imem_req_ready held 0 for 4 cycles, then redirect to 32'h8000_0040 -> addr changes to 32'h8000_0040 while valid stays 1; accepted address is 32'h8000_0040.
6. Redirect to 32'hFFFF_FFFC, consume one instruction -> next request addr 32'h0000_0000. Assert rst=0 while in WAIT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/ysyx_24120013_ifetch.sv
// Instruction fetch stage feeding the decode unit.
// Holds the PC, issues one word-aligned request at a time to instruction
// memory, hands the returned word and its PC to the IDU over valid/ready,
// and accepts redirects from execute (redirect outranks every other event).
// Optional build macro IFETCH_PERF_EN adds fetch and stall counters.
module ysyx_24120013_ifetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_err
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_OUT  = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  // Clears the two low address bits so every fetch is word aligned.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(3'd4);

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   pc_r, pc_s;
  logic                    drop_r, drop_s;
  logic                    req_valid_r;
  logic                    inst_valid_r, inst_valid_s;
  logic [DATA_WIDTH-1:0]   inst_r, inst_s;
  logic [ADDR_WIDTH-1:0]   inst_pc_r, inst_pc_s;
  logic                    fetch_err_r, fetch_err_s;
  logic [ADDR_WIDTH-1:0]   redir_pc_s;
  logic                    accept_s;

  assign redir_pc_s = redirect_pc & ALIGN_MASK;
  assign accept_s   = req_valid_r & imem_req_ready;

  // Next-state and datapath decisions; redirect is evaluated first in every state.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    drop_s       = drop_r;
    inst_valid_s = inst_valid_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    fetch_err_s  = fetch_err_r;
    case (state_r)
      ST_IDLE: begin
        if (redirect_en) begin
          pc_s = redir_pc_s;
        end else begin
          pc_s = pc_r;
        end
        state_s = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_en) begin
          pc_s = redir_pc_s;
          if (accept_s) begin
            // The old address already went out; its response must be dropped.
            drop_s  = 1'b1;
            state_s = ST_WAIT;
          end else begin
            state_s = ST_REQ;
          end
        end else if (accept_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect_en) begin
          pc_s = redir_pc_s;
          if (imem_rsp_valid) begin
            // Response of the stale request lands now: discard it directly.
            drop_s  = 1'b0;
            state_s = ST_REQ;
          end else begin
            drop_s  = 1'b1;
            state_s = ST_WAIT;
          end
        end else if (imem_rsp_valid) begin
          if (drop_r) begin
            drop_s  = 1'b0;
            state_s = ST_REQ;
          end else if (imem_rsp_err) begin
            fetch_err_s = 1'b1;
            state_s     = ST_HALT;
          end else begin
            inst_s       = imem_rsp_data;
            inst_pc_s    = pc_r;
            inst_valid_s = 1'b1;
            state_s      = ST_OUT;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (redirect_en) begin
          // A simultaneous inst_ready still completes the transfer; no pc+4.
          inst_valid_s = 1'b0;
          pc_s         = redir_pc_s;
          state_s      = ST_REQ;
        end else if (inst_ready) begin
          inst_valid_s = 1'b0;
          pc_s         = pc_r + PC_STEP;
          state_s      = ST_REQ;
        end else begin
          state_s = ST_OUT;
        end
      end
      ST_HALT: begin
        if (redirect_en) begin
          pc_s        = redir_pc_s;
          fetch_err_s = 1'b0;
          state_s     = ST_REQ;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        // Unreachable encodings recover through IDLE with nothing presented.
        inst_valid_s = 1'b0;
        drop_s       = 1'b0;
        state_s      = ST_IDLE;
      end
    endcase
  end

  // State, PC and output registers; async reset returns everything to the boot point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      drop_r       <= 1'b0;
      req_valid_r  <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_r       <= '0;
      inst_pc_r    <= '0;
      fetch_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      drop_r       <= drop_s;
      req_valid_r  <= (state_s == ST_REQ);
      inst_valid_r <= inst_valid_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      fetch_err_r  <= fetch_err_s;
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r & ALIGN_MASK;
  assign inst_valid     = inst_valid_r;
  assign inst           = inst_r;
  assign inst_pc        = inst_pc_r;
  assign fetch_err      = fetch_err_r;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_stall_r;

  // Counts delivered instructions and cycles spent requesting or waiting on memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_r <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (inst_valid_r && inst_ready) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end else begin
        perf_fetch_r <= perf_fetch_r;
      end
      if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_r;
  assign perf_stall_cnt = perf_stall_r;
`else
  // Counters are not built; the fetch behaviour is unchanged.
`endif

endmodule
